smi_ctrl: RTL
=============

// Module: smi_ctrl
// PURPOSE
//  - Clause-22 MDIO/MDC management master for the GMII PHY; fills the SMI slot beside the rx path.
//  - Serialises one register read/write per command from the CSR side onto MDC/MDIO.
//  - Returns read data and an error flag. The top level ties MDIO_O/MDIO_OE/MDIO_I to the MDIO pad tristate.
// PARAMETERS
//  CLK_DIV      20       CLK cycles per MDC half-period (>=2; MDC = f_CLK/(2*CLK_DIV))
//  POLL_PERIOD  1000000  CLK cycles between autonomous BMSR polls (SMI_LINK_POLL_EN only)
//  POLL_PHY     5'd0     PHY address used for the link poll
// PORTS
//  CLK        in   1   single clock, all logic on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  cmd_v      in   1   command valid
//  cmd_ready  out  1   command accepted when cmd_v&&cmd_ready
//  cmd_we     in   1   1=write, 0=read
//  cmd_phy    in   5   PHY address
//  cmd_reg    in   5   register address
//  cmd_wdata  in   16  write data
//  rsp_v      out  1   one-cycle completion pulse (reads and writes)
//  rsp_rdata  out  16  read data; valid with rsp_v, 0 for writes
//  rsp_err    out  1   read turnaround bit sampled 1 (no PHY); valid with rsp_v
//  busy       out  1   transaction in progress
//  MDC        out  1   management clock
//  MDIO_O     out  1   MDIO drive value
//  MDIO_OE    out  1   MDIO output enable
//  MDIO_I     in   1   MDIO pad input
//  link_up    out  1   BMSR bit 2 from last poll (SMI_LINK_POLL_EN only)
// BEHAVIOUR
//  - Reset: MDC=0, MDIO_O=1, MDIO_OE=0, cmd_ready=0 during reset (1 after), rsp_v=0, rsp_rdata=0,
//    rsp_err=0, busy=0, link_up=0, state IDLE, divider cleared.
//  - Frame (64 bits, MSB first): 32x'1' PRE, ST=01, OP(01 wr / 10 rd), PHYAD[4:0], REGAD[4:0],
//    TA (wr: 10 driven; rd: released), DATA[15:0].
//  - FSM: IDLE -> PRE (bits 0..31) -> FRAME (bits 32..63) -> DONE -> IDLE.
//  - IDLE: cmd_ready=1, MDC low. Accept latches cmd into a 64-bit shift reg; busy=1 next cycle.
//  - Timing: bit n is driven starting the cycle after accept (n=0) or at MDC falling edges.
//    MDC rises CLK_DIV cycles after each bit starts and falls CLK_DIV cycles later.
//    Bit period = 2*CLK_DIV CLK cycles.
//  - Read: MDIO_OE=0 from bit 46 (first TA bit) to the end of the frame.
//    MDIO_I is sampled on the MDC rising edges of bit 47 (-> rsp_err) and bits 48..63 (-> rdata, MSB first).
//    MDIO_I is assumed pre-synchronised by a 2-flop synchroniser inside this block; the sample
//    point is the rising-edge cycle plus 2.
//  - DONE: entered at the MDC falling edge ending bit 63, exactly 128*CLK_DIV cycles after accept.
//    In DONE: rsp_v=1 for one cycle, MDIO_OE=0, MDIO_O=1, busy=0. Next cycle is IDLE with cmd_ready=1.
//  - Held rsp_rdata/rsp_err keep their values until the next rsp_v.
//  - cmd_v while busy is ignored (cmd_ready=0); the requester holds cmd_v.
//  - Write: MDIO_OE=1 for all 64 bits.
//  - Async reset mid-frame: immediate abort, no rsp_v, MDIO released, MDC low.
// CONFIGURATION
//  - SMI_LINK_POLL_EN defined:
//    - A POLL_PERIOD down-counter runs while IDLE.
//    - At zero it issues an internal read of POLL_PHY reg 1 (BMSR), with priority over cmd_v
//      on the same cycle; cmd_ready=0 that cycle.
//    - A poll completion does not pulse rsp_v. link_up <= BMSR[2] if !err, else 0.
//    - The counter reloads at poll completion.
//  - SMI_LINK_POLL_EN undefined: no poll counter, no link_up port; only external commands run.
// STRUCTURE
//  - smi_pkg: SMI_ST=2'b01, SMI_OP_WR=2'b01, SMI_OP_RD=2'b10, SMI_FRAME_BITS=64, SMI_PRE_BITS=32,
//    SMI_TA_BIT=46, SMI_REG_BMSR=5'd1, SMI_BMSR_LINK=2, FSM state encoding.
//  - Sub-module smi_clk_div: CLK_DIV counter producing MDC plus one-cycle mdc_rise/mdc_fall
//    strobes, held in reset (MDC=0) while IDLE.
// TESTING
//  - Sim PHY model on MDIO; CLK_DIV=2 unless noted.
//  1. Write phy=1 reg=0 data=16'h1140 -> MDIO shows 32x1,01,01,00001,00000,10,0001000101000000;
//     OE high for all 64 bits; rsp_v exactly 256 cycles after accept.
//  2. Read phy=1 reg=2, model returns 16'h0141 -> rsp_rdata=16'h0141, rsp_err=0;
//     MDIO_OE=0 from bit 46 to the end.
//  3. Read phy=31 with no model responding (pull-up) -> rsp_err=1, rsp_rdata=16'hFFFF.
//  4. Back-to-back: cmd_v held high for 2 cmds -> second accepted the cycle after rsp_v;
//     cmd_ready=0 throughout the first frame.
//  5. rst_n low at bit 40 of a write -> next CLK: MDC=0, MDIO_OE=0, busy=0; no rsp_v;
//     a following read completes normally.
//  6. (SMI_LINK_POLL_EN, POLL_PERIOD=300) BMSR=16'h796D -> link_up=1 after first poll;
//     poll and cmd_v on the same cycle -> poll first, cmd second.

Source files
------------

// File: rtl/smi_pkg.sv
// Shared constants, FSM encoding and frame builder for the Clause-22 MDIO master.
package smi_pkg;

  localparam logic [1:0] SMI_ST    = 2'b01;
  localparam logic [1:0] SMI_OP_WR = 2'b01;
  localparam logic [1:0] SMI_OP_RD = 2'b10;

  localparam int unsigned SMI_FRAME_BITS = 64;
  localparam int unsigned SMI_PRE_BITS   = 32;
  localparam int unsigned SMI_TA_BIT     = 46;

  localparam logic [4:0]  SMI_REG_BMSR  = 5'd1;
  localparam int unsigned SMI_BMSR_LINK = 2;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StFrame,
    StDone
  } smi_state_e;

  // Full 64-bit frame, MSB first. Read frames carry ones in TA/DATA; those bits are released.
  function automatic logic [63:0] smi_frame(input logic        we,
                                            input logic [4:0]  phy,
                                            input logic [4:0]  regad,
                                            input logic [15:0] wdata);
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] data;
    op   = we ? SMI_OP_WR : SMI_OP_RD;
    ta   = we ? 2'b10 : 2'b11;
    data = we ? wdata : 16'hFFFF;
    return {32'hFFFF_FFFF, SMI_ST, op, phy, regad, ta, data};
  endfunction

endpackage

// File: rtl/smi_clk_div.sv
// MDC generator: toggles MDC every ClkDiv cycles while running; held low and cleared on hold.
// The rise/fall strobes are high in the cycle whose closing edge changes MDC.
module smi_clk_div #(
  parameter int unsigned ClkDiv = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hold_i,
  output logic mdc_o,
  output logic mdc_rise_o,
  output logic mdc_fall_o
);

  logic [15:0] cnt_q;
  logic        mdc_q;
  logic        wrap;

  assign wrap       = (cnt_q == 16'(ClkDiv - 1));
  assign mdc_rise_o = !hold_i && wrap && !mdc_q;
  assign mdc_fall_o = !hold_i && wrap && mdc_q;
  assign mdc_o      = mdc_q;

  // Half-period counter and MDC toggle flop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (hold_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/smi_ctrl.sv
// Clause-22 MDIO/MDC management master: one register read or write per accepted command.
// Optional autonomous BMSR link poll is built when SMI_LINK_POLL_EN is defined.
module smi_ctrl
  import smi_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 20,
  parameter int unsigned POLL_PERIOD = 1000000,
  parameter logic [4:0]  POLL_PHY    = 5'd0
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        cmd_v,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_v,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_OE,
`ifdef SMI_LINK_POLL_EN
  output logic        link_up,
`endif
  input  logic        MDIO_I
);

  smi_state_e  state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [63:0] sreg_q, sreg_d;
  logic        we_q, we_d;
  logic        rdy_q;
  logic        active, div_hold, mdc_rise, mdc_fall;
  logic        cmd_fire, frame_end, capture;
  logic        poll_start, poll_active;
  logic        mdio_s1_q, mdio_s2_q;
  logic [1:0]  rise_pipe_q;
  logic [15:0] rdata_sh_q, rdata_d;
  logic        err_sh_q, err_d;

  assign active    = (state_q == StPre) || (state_q == StFrame);
  assign div_hold  = !active;
  assign busy      = active;
  assign cmd_ready = rdy_q && (state_q == StIdle) && !poll_start;
  assign cmd_fire  = cmd_v && cmd_ready;
  assign frame_end = (state_q == StFrame) && mdc_fall && (bit_q == 6'(SMI_FRAME_BITS - 1));
  assign rsp_v     = (state_q == StDone) && !poll_active;
  assign MDIO_OE   = active && (we_q || (bit_q < 6'(SMI_TA_BIT)));
  assign MDIO_O    = MDIO_OE ? sreg_q[63] : 1'b1;
  // Synchroniser delays MDIO_I by two cycles, so sample two cycles after the MDC rise.
  assign capture   = rise_pipe_q[1] && (state_q == StFrame) && !we_q;

  smi_clk_div #(
    .ClkDiv(CLK_DIV)
  ) u_clk_div (
    .clk_i     (CLK),
    .rst_ni    (rst_n),
    .hold_i    (div_hold),
    .mdc_o     (MDC),
    .mdc_rise_o(mdc_rise),
    .mdc_fall_o(mdc_fall)
  );

  // Keep cmd_ready low until the first clock after reset release
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Next-state, shift register and bit counter
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    we_d    = we_q;
    unique case (state_q)
      StIdle: begin
        if (poll_start) begin
          sreg_d  = smi_frame(1'b0, POLL_PHY, SMI_REG_BMSR, 16'h0000);
          we_d    = 1'b0;
          bit_d   = '0;
          state_d = StPre;
        end else if (cmd_fire) begin
          sreg_d  = smi_frame(cmd_we, cmd_phy, cmd_reg, cmd_wdata);
          we_d    = cmd_we;
          bit_d   = '0;
          state_d = StPre;
        end
      end
      StPre: begin
        if (mdc_fall) begin
          sreg_d = {sreg_q[62:0], 1'b1};
          bit_d  = bit_q + 6'd1;
          if (bit_q == 6'(SMI_PRE_BITS - 1)) state_d = StFrame;
        end
      end
      StFrame: begin
        if (mdc_fall) begin
          if (bit_q == 6'(SMI_FRAME_BITS - 1)) begin
            state_d = StDone;
          end else begin
            sreg_d = {sreg_q[62:0], 1'b1};
            bit_d  = bit_q + 6'd1;
          end
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // FSM and frame state registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bit_q   <= '0;
      sreg_q  <= '1;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      we_q    <= we_d;
    end
  end

  // Read data assembly: bit 47 is the PHY's TA drive, bits 48..63 the register value
  always_comb begin
    rdata_d = rdata_sh_q;
    err_d   = err_sh_q;
    if (cmd_fire || poll_start) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end else if (capture) begin
      if (bit_q == 6'(SMI_TA_BIT + 1))       err_d   = mdio_s2_q;
      else if (bit_q > 6'(SMI_TA_BIT + 1))  rdata_d = {rdata_sh_q[14:0], mdio_s2_q};
    end
  end

  // MDIO_I synchroniser, rise-strobe delay line and read shifters
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mdio_s1_q   <= 1'b1;
      mdio_s2_q   <= 1'b1;
      rise_pipe_q <= '0;
      rdata_sh_q  <= '0;
      err_sh_q    <= 1'b0;
    end else begin
      mdio_s1_q   <= MDIO_I;
      mdio_s2_q   <= mdio_s1_q;
      rise_pipe_q <= {rise_pipe_q[0], mdc_rise};
      rdata_sh_q  <= rdata_d;
      err_sh_q    <= err_d;
    end
  end

  // Response registers hold until the next external completion
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (frame_end && !poll_active) begin
      rsp_rdata <= we_q ? 16'h0000 : rdata_d;
      rsp_err   <= we_q ? 1'b0 : err_d;
    end
  end

`ifdef SMI_LINK_POLL_EN
  logic [31:0] poll_cnt_q;
  logic        poll_q;

  assign poll_start  = rdy_q && (state_q == StIdle) && (poll_cnt_q == 32'd0);
  assign poll_active = poll_q;

  // Poll interval counter (runs only while idle), poll ownership and link status
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt_q <= 32'(POLL_PERIOD);
      poll_q     <= 1'b0;
      link_up    <= 1'b0;
    end else begin
      if (poll_start)              poll_q <= 1'b1;
      else if (state_q == StDone)  poll_q <= 1'b0;
      if ((state_q == StDone) && poll_q) begin
        poll_cnt_q <= 32'(POLL_PERIOD);
      end else if ((state_q == StIdle) && (poll_cnt_q != 32'd0)) begin
        poll_cnt_q <= poll_cnt_q - 32'd1;
      end
      if (frame_end && poll_q) link_up <= !err_d && rdata_d[SMI_BMSR_LINK];
    end
  end
`else
  logic unused_poll_cfg;
  assign poll_start      = 1'b0;
  assign poll_active     = 1'b0;
  assign unused_poll_cfg = ^{POLL_PHY, 32'(POLL_PERIOD)};
`endif

endmodule
